mpu_bus_initiator: RTL and testbench

//  Host-side initiator for the ChronoCube MPU bus. It turns a valid/ready request from the host
//  (SPI bridge, soft CPU, testbench) into timed active-low _mpu_* bus cycles.
//  It maps the flat banked host address onto the 16-bit MPU window. A MEM_CTRL[15:8] bank write
//  is inserted only when the cached bank differs.

---
 rtl/mpu_bus_initiator_pkg.sv | 28 ++
 rtl/mpu_bus_initiator_if.sv | 34 +++
 rtl/mpu_bus_initiator_wait_timer.sv | 27 ++
 rtl/mpu_bus_initiator.sv | 190 +++++++++++++++++++
 tb/tb_mpu_bus_initiator.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_bus_initiator_pkg.sv
// Shared definitions for the ChronoCube MPU bus initiator: address map widths,
// MEM_CTRL location, FSM states and the host-to-MPU address mapping.
package mpu_bus_initiator_pkg;

  localparam int PAGE_OFFSET_WIDTH = 15;
  localparam int BANK_WIDTH        = 8;
  localparam int HOST_ADDR_WIDTH   = PAGE_OFFSET_WIDTH + BANK_WIDTH;
  localparam int MPU_ADDR_WIDTH    = PAGE_OFFSET_WIDTH + 1;

  localparam logic [MPU_ADDR_WIDTH-1:0] MEM_CTRL_ADDR_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BANK_WR,
    ST_BANK_GAP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Bank 0 lives in the fixed lower page; every other bank appears in the upper page.
  function automatic logic [MPU_ADDR_WIDTH-1:0] map_mpu_addr(
    input logic [BANK_WIDTH-1:0]        bank,
    input logic [PAGE_OFFSET_WIDTH-1:0] offset
  );
    return {(bank != '0), offset};
  endfunction

endpackage

// File: rtl/mpu_bus_initiator_if.sv
// Host request/response handshake plus the active-low ChronoCube MPU bus.
// The master modport is the initiator's view; slave is the host/bus-side view.
interface mpu_bus_initiator_if;
  import mpu_bus_initiator_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [HOST_ADDR_WIDTH-1:0] req_addr;
  logic [1:0]                 req_be;
  logic [15:0]                req_wdata;
  logic                       rsp_valid;
  logic [15:0]                rsp_rdata;
  logic                       _mpu_en;
  logic                       _mpu_rd;
  logic                       _mpu_wr;
  logic [1:0]                 _mpu_be;
  logic [MPU_ADDR_WIDTH-1:0]  mpu_addr;
  logic [15:0]                mpu_data_out;
  logic [15:0]                mpu_data_in;

  modport master (
    input  req_valid, req_write, req_addr, req_be, req_wdata, mpu_data_in,
    output req_ready, rsp_valid, rsp_rdata,
    output _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_data_out
  );

  modport slave (
    output req_valid, req_write, req_addr, req_be, req_wdata, mpu_data_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_data_out
  );

endinterface

// File: rtl/mpu_bus_initiator_wait_timer.sv
// Loadable down-counter that times how long the bus strobes stay low.
// done is high while the count sits at zero, i.e. on the last cycle of a timed phase.
module mpu_bus_initiator_wait_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mpu_bus_initiator.sv
// Host-side initiator for the ChronoCube MPU bus: turns valid/ready requests into
// registered active-low bus cycles, inserting a MEM_CTRL bank write on a bank-cache miss.
module mpu_bus_initiator
  import mpu_bus_initiator_pkg::*;
#(
  parameter int                        RD_WAIT       = 2,
  parameter int                        WR_WAIT       = 1,
  parameter logic [MPU_ADDR_WIDTH-1:0] MEM_CTRL_ADDR = MEM_CTRL_ADDR_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  mpu_bus_initiator_if.master bus
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int TW       = $clog2(MAX_WAIT) + 1;
  localparam logic [TW-1:0] RD_LOAD = TW'(RD_WAIT - 1);
  localparam logic [TW-1:0] WR_LOAD = TW'(WR_WAIT - 1);

  state_t                       state, state_nx;
  logic                         lat_write;
  logic [BANK_WIDTH-1:0]        lat_bank;
  logic [PAGE_OFFSET_WIDTH-1:0] lat_offset;
  logic [1:0]                   lat_be;
  logic [15:0]                  lat_wdata;
  logic [BANK_WIDTH-1:0]        cache_bank;
  logic                         cache_valid;
  logic [BANK_WIDTH-1:0]        in_bank;
  logic [PAGE_OFFSET_WIDTH-1:0] in_offset;
  logic                         accept, bank_miss, ctrl_write_hit;
  logic                         tmr_load, tmr_done;
  logic [TW-1:0]                tmr_value;
  logic                         en_n_nx, rd_n_nx, wr_n_nx, ready_nx, rsp_nx, capture;
  logic [1:0]                   be_n_nx;
  logic [MPU_ADDR_WIDTH-1:0]    addr_nx;
  logic [15:0]                  dout_nx;

  assign in_bank   = bus.req_addr[HOST_ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
  assign in_offset = bus.req_addr[PAGE_OFFSET_WIDTH-1:0];
  assign accept    = (state == ST_IDLE) && bus.req_valid && bus.req_ready;
  assign bank_miss = (in_bank != '0) && !(cache_valid && (cache_bank == in_bank));

  // A host write of MEM_CTRL's upper byte moves the bank register behind our back.
  assign ctrl_write_hit = lat_write && (lat_bank == '0) && lat_be[1] &&
                          (map_mpu_addr(lat_bank, lat_offset) == MEM_CTRL_ADDR);

  mpu_bus_initiator_wait_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and next bus values; outputs are registered so they line up with the state.
  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    en_n_nx   = 1'b1;
    rd_n_nx   = 1'b1;
    wr_n_nx   = 1'b1;
    be_n_nx   = 2'b11;
    addr_nx   = bus.mpu_addr;
    dout_nx   = bus.mpu_data_out;
    ready_nx  = 1'b0;
    rsp_nx    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_nx = 1'b1;
        if (accept) begin
          ready_nx = 1'b0;
          tmr_load = 1'b1;
          en_n_nx  = 1'b0;
          if (bank_miss) begin
            state_nx  = ST_BANK_WR;
            tmr_value = WR_LOAD;
            wr_n_nx   = 1'b0;
            be_n_nx   = 2'b01;
            addr_nx   = MEM_CTRL_ADDR;
            dout_nx   = {in_bank, 8'h00};
          end else begin
            state_nx  = ST_ACCESS;
            tmr_value = bus.req_write ? WR_LOAD : RD_LOAD;
            rd_n_nx   = bus.req_write;
            wr_n_nx   = !bus.req_write;
            be_n_nx   = ~bus.req_be;
            addr_nx   = map_mpu_addr(in_bank, in_offset);
            dout_nx   = bus.req_write ? bus.req_wdata : 16'h0000;
          end
        end
      end
      ST_BANK_WR: begin
        if (tmr_done) begin
          state_nx = ST_BANK_GAP;
        end else begin
          en_n_nx = 1'b0;
          wr_n_nx = 1'b0;
          be_n_nx = 2'b01;
        end
      end
      ST_BANK_GAP: begin
        state_nx  = ST_ACCESS;
        tmr_load  = 1'b1;
        tmr_value = lat_write ? WR_LOAD : RD_LOAD;
        en_n_nx   = 1'b0;
        rd_n_nx   = lat_write;
        wr_n_nx   = !lat_write;
        be_n_nx   = ~lat_be;
        addr_nx   = map_mpu_addr(lat_bank, lat_offset);
        dout_nx   = lat_write ? lat_wdata : 16'h0000;
      end
      ST_ACCESS: begin
        if (tmr_done) begin
          state_nx = ST_RESP;
          rsp_nx   = 1'b1;
          capture  = !lat_write;
        end else begin
          en_n_nx = 1'b0;
          rd_n_nx = lat_write;
          wr_n_nx = !lat_write;
          be_n_nx = ~lat_be;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus registers, request latch and the bank cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus._mpu_en      <= 1'b1;
      bus._mpu_rd      <= 1'b1;
      bus._mpu_wr      <= 1'b1;
      bus._mpu_be      <= 2'b11;
      bus.mpu_addr     <= '0;
      bus.mpu_data_out <= '0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      lat_write        <= 1'b0;
      lat_bank         <= '0;
      lat_offset       <= '0;
      lat_be           <= '0;
      lat_wdata        <= '0;
      cache_bank       <= '0;
      cache_valid      <= 1'b0;
    end else begin
      bus._mpu_en      <= en_n_nx;
      bus._mpu_rd      <= rd_n_nx;
      bus._mpu_wr      <= wr_n_nx;
      bus._mpu_be      <= be_n_nx;
      bus.mpu_addr     <= addr_nx;
      bus.mpu_data_out <= dout_nx;
      bus.req_ready    <= ready_nx;
      bus.rsp_valid    <= rsp_nx;
      if (capture) begin
        bus.rsp_rdata <= bus.mpu_data_in;
      end
      if (accept) begin
        lat_write  <= bus.req_write;
        lat_bank   <= in_bank;
        lat_offset <= in_offset;
        lat_be     <= bus.req_be;
        lat_wdata  <= bus.req_wdata;
      end
      if ((state == ST_BANK_WR) && tmr_done) begin
        cache_bank  <= lat_bank;
        cache_valid <= 1'b1;
      end else if ((state == ST_RESP) && ctrl_write_hit) begin
        cache_bank  <= lat_wdata[15:8];
        cache_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpu_bus_initiator.sv
// Self-checking bench for mpu_bus_initiator: directed host requests against a sync-RAM
// slave, with a transaction-level model predicting every bus cycle.
module tb_mpu_bus_initiator;
  import mpu_bus_initiator_pkg::*;

  localparam int          RD_WAIT  = 2;
  localparam int          WR_WAIT  = 1;
  localparam logic [15:0] MEM_CTRL = 16'h0000;

  typedef struct {
    bit          en_n;
    bit          rd_n;
    bit          wr_n;
    logic [1:0]  be_n;
    logic [15:0] addr;
    logic [15:0] dout;
    bit          rsp;
    bit          ready;
    bit          chk_rdata;
    logic [15:0] rdata;
  } cycle_t;

  logic clk;
  logic rst_n;
  mpu_bus_initiator_if bus();

  mpu_bus_initiator #(
    .RD_WAIT       (RD_WAIT),
    .WR_WAIT       (WR_WAIT),
    .MEM_CTRL_ADDR (MEM_CTRL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  cycle_t      exp_q[$];
  logic [15:0] model_mem [0:65535];
  logic [7:0]  model_cache;
  bit          model_cache_valid;
  int          ctrl_writes = 0;
  logic [1:0]  last_ctrl_be_n = 2'b11;
  logic [15:0] last_ctrl_data = 16'h0000;
  logic [15:0] ram [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic cycle_t mkCycle(bit en_n, bit rd_n, bit wr_n, logic [1:0] be_n,
                                     logic [15:0] addr, logic [15:0] dout, bit rsp, bit ready);
    cycle_t c;
    c.en_n = en_n; c.rd_n = rd_n; c.wr_n = wr_n; c.be_n = be_n;
    c.addr = addr; c.dout = dout; c.rsp = rsp; c.ready = ready;
    c.chk_rdata = 1'b0; c.rdata = 16'h0000;
    return c;
  endfunction

  // Slave: synchronous RAM, one cycle read latency; word 0 is the MEM_CTRL register.
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    ram[16'h0010] = 16'hBEEF;
    bus.mpu_data_in = 16'h0000;
    forever begin
      @(posedge clk);
      if (!bus._mpu_en && !bus._mpu_wr) begin
        if (!bus._mpu_be[1]) ram[bus.mpu_addr][15:8] = bus.mpu_data_out[15:8];
        if (!bus._mpu_be[0]) ram[bus.mpu_addr][7:0]  = bus.mpu_data_out[7:0];
        if (bus.mpu_addr == MEM_CTRL) begin
          ctrl_writes++;
          last_ctrl_be_n = bus._mpu_be;
          last_ctrl_data = bus.mpu_data_out;
        end
      end
      if (!bus._mpu_en && !bus._mpu_rd) bus.mpu_data_in <= ram[bus.mpu_addr];
    end
  end

  // Model: from an accepted request, predict every bus cycle up to and including the response.
  task automatic modelAccept(input bit wr, input logic [22:0] addr, input logic [1:0] be, input logic [15:0] wdata);
    logic [7:0]  bank;
    logic [15:0] maddr;
    cycle_t      c;
    bank  = addr[22:15];
    maddr = (bank != 8'h00) ? (16'h8000 | {1'b0, addr[14:0]}) : {1'b0, addr[14:0]};
    if (bank != 8'h00 && !(model_cache_valid && model_cache == bank)) begin
      for (int i = 0; i < WR_WAIT; i++)
        exp_q.push_back(mkCycle(1'b0, 1'b1, 1'b0, 2'b01, MEM_CTRL, {bank, 8'h00}, 1'b0, 1'b0));
      exp_q.push_back(mkCycle(1'b1, 1'b1, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0, 1'b0));
      model_cache           = bank;
      model_cache_valid     = 1'b1;
      model_mem[MEM_CTRL][15:8] = bank;
    end
    for (int i = 0; i < (wr ? WR_WAIT : RD_WAIT); i++)
      exp_q.push_back(mkCycle(1'b0, wr, !wr, ~be, maddr, wr ? wdata : 16'h0000, 1'b0, 1'b0));
    c = mkCycle(1'b1, 1'b1, 1'b1, 2'b11, 16'h0, 16'h0, 1'b1, 1'b0);
    c.chk_rdata = !wr;
    c.rdata     = model_mem[maddr];
    exp_q.push_back(c);
    if (wr) begin
      if (be[1]) model_mem[maddr][15:8] = wdata[15:8];
      if (be[0]) model_mem[maddr][7:0]  = wdata[7:0];
      if (maddr == MEM_CTRL && be[1]) begin
        model_cache       = wdata[15:8];
        model_cache_valid = 1'b1;
      end
    end
  endtask

  // Per-cycle compare against the model, or against the reset values while reset is held.
  initial begin
    cycle_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_en",    bus._mpu_en, 1);
        checkOutput("rst_rd",    bus._mpu_rd, 1);
        checkOutput("rst_wr",    bus._mpu_wr, 1);
        checkOutput("rst_be",    bus._mpu_be, 2'b11);
        checkOutput("rst_addr",  bus.mpu_addr, 16'h0);
        checkOutput("rst_dout",  bus.mpu_data_out, 16'h0);
        checkOutput("rst_ready", bus.req_ready, 1);
        checkOutput("rst_rsp",   bus.rsp_valid, 0);
        checkOutput("rst_rdata", bus.rsp_rdata, 16'h0);
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mkCycle(1'b1, 1'b1, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("cyc_en",    bus._mpu_en, e.en_n);
        checkOutput("cyc_rd",    bus._mpu_rd, e.rd_n);
        checkOutput("cyc_wr",    bus._mpu_wr, e.wr_n);
        checkOutput("cyc_rsp",   bus.rsp_valid, e.rsp);
        checkOutput("cyc_ready", bus.req_ready, e.ready);
        if (!e.en_n) begin
          checkOutput("cyc_be",   bus._mpu_be, e.be_n);
          checkOutput("cyc_addr", bus.mpu_addr, e.addr);
          checkOutput("cyc_dout", bus.mpu_data_out, e.dout);
        end
        if (e.chk_rdata) checkOutput("cyc_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic driveUntilAccept(input bit wr, input logic [22:0] addr, input logic [1:0] be,
                                  input logic [15:0] wdata, output bit ok);
    int waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = (waited < 20);
    if (!ok) begin
      reportTimeout("accept");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    modelAccept(wr, addr, be, wdata);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit wr, input logic [22:0] addr, input logic [1:0] be,
                               input logic [15:0] wdata, output int latency, output logic [15:0] rdata);
    bit ok;
    latency = 0;
    rdata   = 16'h0000;
    driveUntilAccept(wr, addr, be, wdata, ok);
    if (!ok) return;
    do begin
      @(negedge clk);
      latency++;
    end while (bus.rsp_valid !== 1'b1 && latency < 20);
    if (bus.rsp_valid !== 1'b1) reportTimeout("response");
    rdata = bus.rsp_rdata;
  endtask

  initial begin
    int          lat;
    int          base;
    logic [15:0] rd;
    bit          ok;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = 2'b00;
    bus.req_wdata = 16'h0000;
    for (int i = 0; i < 65536; i++) model_mem[i] = 16'h0000;
    model_mem[16'h0010] = 16'hBEEF;
    model_cache       = 8'h00;
    model_cache_valid = 1'b0;

    // Reset held for three cycles, then released.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t1_en_in_reset", bus._mpu_en, 1);
    checkOutput("t1_be_in_reset", bus._mpu_be, 2'b11);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t1_ready", bus.req_ready, 1);
    checkOutput("t1_rsp",   bus.rsp_valid, 0);

    // Page-0 read hit.
    base = ctrl_writes;
    applyStimulus(1'b0, 23'h000010, 2'b11, 16'h0000, lat, rd);
    checkOutput("t2_latency", lat, 3);
    checkOutput("t2_rdata", rd, 16'hBEEF);
    checkOutput("t2_no_bank_wr", ctrl_writes - base, 0);

    // Cold-cache banked write.
    base = ctrl_writes;
    applyStimulus(1'b1, 23'h0D4000, 2'b11, 16'h1234, lat, rd);
    checkOutput("t3_latency", lat, 4);
    checkOutput("t3_bank_wr_count", ctrl_writes - base, 1);
    checkOutput("t3_bank_wr_be", last_ctrl_be_n, 2'b01);
    checkOutput("t3_bank_wr_data", last_ctrl_data, 16'h1A00);
    checkOutput("t3_ram_c000", ram[16'hC000], 16'h1234);

    // Same bank hits; a different bank misses.
    base = ctrl_writes;
    applyStimulus(1'b0, 23'h0D4000, 2'b11, 16'h0000, lat, rd);
    checkOutput("t4_hit_latency", lat, 3);
    checkOutput("t4_hit_rdata", rd, 16'h1234);
    checkOutput("t4_hit_no_bank_wr", ctrl_writes - base, 0);
    applyStimulus(1'b0, 23'h0D8000, 2'b11, 16'h0000, lat, rd);
    checkOutput("t4_miss_latency", lat, 5);
    checkOutput("t4_miss_bank_wr", ctrl_writes - base, 1);
    checkOutput("t4_miss_bank_data", last_ctrl_data, 16'h1B00);

    // Host writes to MEM_CTRL: full word updates the cache, low byte only does not.
    applyStimulus(1'b1, 23'h000000, 2'b11, 16'h2201, lat, rd);
    checkOutput("t5_ctrl_wr_latency", lat, 2);
    base = ctrl_writes;
    applyStimulus(1'b0, 23'h110005, 2'b11, 16'h0000, lat, rd);
    checkOutput("t5_bank22_no_bank_wr", ctrl_writes - base, 0);
    checkOutput("t5_bank22_latency", lat, 3);
    applyStimulus(1'b1, 23'h000000, 2'b01, 16'h3301, lat, rd);
    checkOutput("t5_ctrl_low_only", ram[MEM_CTRL], 16'h2201);
    base = ctrl_writes;
    applyStimulus(1'b0, 23'h198005, 2'b11, 16'h0000, lat, rd);
    checkOutput("t5_bank33_bank_wr", ctrl_writes - base, 1);
    checkOutput("t5_bank33_latency", lat, 5);
    checkOutput("t5_ctrl_preserved_bit0", ram[MEM_CTRL], 16'h3301);

    // Reset during the ACCESS phase of a banked read drops it and invalidates the cache.
    driveUntilAccept(1'b0, 23'h0D4000, 2'b11, 16'h0000, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      model_cache_valid = 1'b0;
      #1;
      checkOutput("t6_rd_released", bus._mpu_rd, 1);
      checkOutput("t6_en_released", bus._mpu_en, 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput("t6_no_rsp", bus.rsp_valid, 0);
      end
      base = ctrl_writes;
      applyStimulus(1'b0, 23'h0D4000, 2'b11, 16'h0000, lat, rd);
      checkOutput("t6_reissue_bank_wr", ctrl_writes - base, 1);
      checkOutput("t6_reissue_latency", lat, 5);
      checkOutput("t6_reissue_rdata", rd, 16'h1234);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
